// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Small_MIPS instruction-fetch front end:
// memory map constants, fetch FSM states and the buffered fetch entry.
package fetch_unit_pkg;

   localparam logic [31:0] mem_start = 32'h8002_0000;
   localparam logic [31:0] sz_word   = 32'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH registered entries of {pc, word}, with a flush that
// empties it in one cycle. Storage is not reset; only pointers and count are.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  fetch_entry_t               i_data,
   input  logic                       i_pop,
   input  logic                       i_flush,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_empty,
   output fetch_entry_t               o_head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_pop_ok  = i_pop && (r_count != '0);
   assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

   always_ff @(posedge i_clk) begin
      if (w_push_ok && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited prefetch into a small FIFO,
// valid/ready delivery to the core, and redirect with stale-response dropping.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_INIT = mem_start,
   parameter int          DEPTH   = 4
)
(
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_busy,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_next_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [2:0]  outstanding
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [31:0] DEPTH_U = DEPTH;

   fetch_state_e   r_state;
   fetch_state_e   w_state_nxt;
   logic [31:0]    r_fetch_pc;
   logic [31:0]    r_head_pc;
   logic [31:0]    r_resp_pc;
   logic [2:0]     r_outstanding;
   logic [2:0]     r_drop_cnt;
   logic [2:0]     w_inflight;
   logic [2:0]     w_outstanding_nxt;
   logic [2:0]     w_drop_nxt;
   logic [31:0]    w_redirect_pc;
   logic           w_credit;
   logic           w_accept;
   logic           w_resp;
   logic           w_push;
   logic           w_pop;
   logic           w_fifo_empty;
   logic [CW-1:0]  w_fifo_count;
   fetch_entry_t   w_head;
   fetch_entry_t   w_push_entry;

   assign w_redirect_pc = word_align(redirect_pc);

   // Credit: buffered words plus words still in flight never exceed DEPTH,
   // so every response is guaranteed a FIFO slot.
   assign w_credit = ({{(32-CW){1'b0}}, w_fifo_count} + {29'd0, r_outstanding}) < DEPTH_U;
   assign imem_req  = (r_state != IDLE) && w_credit && !redirect;
   assign imem_addr = r_fetch_pc;

   assign w_accept   = imem_req && !imem_busy;
   assign w_resp     = imem_rvalid && (r_outstanding != 3'd0);
   assign w_inflight = r_outstanding - {2'b00, w_resp};
   assign w_push     = w_resp && (r_drop_cnt == 3'd0) && !redirect;
   assign w_pop      = !w_fifo_empty && instr_ready && !redirect;

   assign w_push_entry = '{pc: r_resp_pc, word: imem_rdata};

   always_comb begin
      w_state_nxt       = r_state;
      w_outstanding_nxt = w_inflight + {2'b00, w_accept};
      w_drop_nxt        = r_drop_cnt;
      // On redirect every word still in flight after this cycle is stale.
      if (redirect) begin
         w_drop_nxt = w_inflight;
      end else if (w_resp && (r_drop_cnt != 3'd0)) begin
         w_drop_nxt = r_drop_cnt - 3'd1;
      end
      case (r_state)
         IDLE:    w_state_nxt = RUN;
         RUN:     if (redirect && (w_drop_nxt != 3'd0)) w_state_nxt = FLUSH;
         FLUSH:   if (w_drop_nxt == 3'd0) w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_pc    <= PC_INIT;
         r_head_pc     <= PC_INIT;
         r_resp_pc     <= PC_INIT;
         r_outstanding <= 3'd0;
         r_drop_cnt    <= 3'd0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         r_drop_cnt    <= w_drop_nxt;
         if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_head_pc  <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + sz_word;
            end
            if (w_pop) begin
               r_head_pc <= r_head_pc + sz_word;
            end
            if (w_push) begin
               r_resp_pc <= r_resp_pc + sz_word;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_head  (w_head)
   );

   // An empty FIFO shows the next PC to be delivered and a zero word.
   assign instr_valid   = !w_fifo_empty;
   assign instr         = instr_valid ? w_head.word : 32'd0;
   assign instr_pc      = instr_valid ? w_head.pc : r_head_pc;
   assign instr_next_pc = instr_pc + sz_word;
   assign outstanding   = r_outstanding;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order latency-configurable memory model,
// a per-cycle vector table, and hand sequences for redirect and async reset.
module tb_fetch_unit;

   localparam logic [31:0] P = 32'h8002_0000;

   logic        clk;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_busy;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_next_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  outstanding;

   int checks = 0;
   int errors = 0;
   int lat    = 1;
   int tick   = 0;

   fetch_unit dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_busy     (imem_busy),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_next_pc (instr_next_pc),
      .instr_ready   (instr_ready),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .outstanding   (outstanding)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mw(input logic [31:0] a);
      return a ^ 32'h1234_5678;
   endfunction

   // In-order instruction memory: a request accepted at edge n is answered
   // during the cycle that begins lat edges later.
   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mq[$];

   initial begin
      bit          acc;
      logic [31:0] acc_addr;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      forever begin
         @(negedge clk);
         acc      = imem_req && !imem_busy && reset_n;
         acc_addr = imem_addr;
         @(posedge clk);
         #1;
         tick++;
         if (!reset_n) begin
            mq.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
         end else begin
            if (acc) mq.push_back('{addr: acc_addr, due: tick + lat - 1});
            if (mq.size() > 0 && mq[0].due <= tick) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mw(mq[0].addr);
               void'(mq.pop_front());
            end else begin
               imem_rvalid = 1'b0;
               imem_rdata  = 32'd0;
            end
         end
      end
   end

   // Protocol monitor: a response with nothing outstanding is never legal.
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n && imem_rvalid && outstanding == 3'd0) begin
            errors++;
            $display("FAIL protocol rvalid_with_zero_outstanding got %0d required >0", outstanding);
         end
      end
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input bit req, input logic [31:0] addr,
                          input bit vld, input logic [31:0] pc, input int out);
      cmp({tag, ".req"}, 32'(imem_req), 32'(req));
      cmp({tag, ".addr"}, imem_addr, addr);
      cmp({tag, ".vld"}, 32'(instr_valid), 32'(vld));
      cmp({tag, ".pc"}, instr_pc, pc);
      cmp({tag, ".npc"}, instr_next_pc, pc + 32'd4);
      cmp({tag, ".out"}, 32'(outstanding), 32'(out));
      if (vld) cmp({tag, ".instr"}, instr, mw(pc));
   endtask

   task automatic chk_rst(input string tag);
      cmp({tag, ".req"}, 32'(imem_req), 32'd0);
      cmp({tag, ".vld"}, 32'(instr_valid), 32'd0);
      cmp({tag, ".instr"}, instr, 32'd0);
      cmp({tag, ".pc"}, instr_pc, P);
      cmp({tag, ".out"}, 32'(outstanding), 32'd0);
   endtask

   task automatic do_reset(input int l, input bit rdy);
      @(posedge clk);
      #1;
      reset_n     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      imem_busy   = 1'b0;
      instr_ready = rdy;
      lat         = l;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic step(input bit redir, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      redirect    = redir;
      redirect_pc = rpc;
      @(negedge clk);
   endtask

   typedef struct {
      bit          rst;
      int          l;
      bit          rdy;
      bit          busy;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_vld;
      logic [31:0] e_pc;
      int          e_out;
   } vec_t;
   vec_t vt[$];

   task automatic add(input bit rst, input int l, input bit rdy, input bit busy,
                      input bit req, input logic [31:0] aoff, input bit vld,
                      input logic [31:0] poff, input int out);
      vt.push_back('{rst: rst, l: l, rdy: rdy, busy: busy, e_req: req,
                     e_addr: P + aoff, e_vld: vld, e_pc: P + poff, e_out: out});
   endtask

   initial begin
      reset_n     = 1'b0;
      imem_busy   = 1'b0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;

      // Streaming from reset, 1-cycle memory, core always ready.
      add(1, 1, 1, 0,  0, 'h00, 0, 'h00, 0);
      add(0, 1, 1, 0,  1, 'h00, 0, 'h00, 0);
      add(0, 1, 1, 0,  1, 'h04, 0, 'h00, 1);
      add(0, 1, 1, 0,  1, 'h08, 1, 'h00, 1);
      add(0, 1, 1, 0,  1, 'h0C, 1, 'h04, 1);
      add(0, 1, 1, 0,  1, 'h10, 1, 'h08, 1);
      // Core stalled: issue stops once DEPTH words are buffered or in flight.
      add(1, 1, 0, 0,  0, 'h00, 0, 'h00, 0);
      add(0, 1, 0, 0,  1, 'h00, 0, 'h00, 0);
      add(0, 1, 0, 0,  1, 'h04, 0, 'h00, 1);
      add(0, 1, 0, 0,  1, 'h08, 1, 'h00, 1);
      add(0, 1, 0, 0,  1, 'h0C, 1, 'h00, 1);
      add(0, 1, 0, 0,  0, 'h10, 1, 'h00, 1);
      add(0, 1, 0, 0,  0, 'h10, 1, 'h00, 0);
      add(0, 1, 0, 0,  0, 'h10, 1, 'h00, 0);
      add(0, 1, 1, 0,  0, 'h10, 1, 'h00, 0);
      add(0, 1, 1, 0,  1, 'h10, 1, 'h04, 0);
      add(0, 1, 1, 0,  1, 'h14, 1, 'h08, 1);
      // Memory busy for three cycles on the second request.
      add(1, 1, 1, 0,  0, 'h00, 0, 'h00, 0);
      add(0, 1, 1, 0,  1, 'h00, 0, 'h00, 0);
      add(0, 1, 1, 1,  1, 'h04, 0, 'h00, 1);
      add(0, 1, 1, 1,  1, 'h04, 1, 'h00, 0);
      add(0, 1, 1, 1,  1, 'h04, 0, 'h04, 0);
      add(0, 1, 1, 0,  1, 'h04, 0, 'h04, 0);
      add(0, 1, 1, 0,  1, 'h08, 0, 'h04, 1);
      add(0, 1, 1, 0,  1, 'h0C, 1, 'h04, 1);
      add(0, 1, 1, 0,  1, 'h10, 1, 'h08, 1);

      @(negedge clk);
      chk_rst("rst0");

      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].rst) begin
            do_reset(vt[i].l, vt[i].rdy);
         end else begin
            @(posedge clk);
            #1;
         end
         instr_ready = vt[i].rdy;
         imem_busy   = vt[i].busy;
         @(negedge clk);
         chk_all($sformatf("v%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_vld,
                 vt[i].e_pc, vt[i].e_out);
      end

      // Redirect with two stale requests in flight, 3-cycle memory.
      do_reset(3, 1);
      @(negedge clk);
      chk_all("d0", 0, P, 0, P, 0);
      step(0, 32'd0);           chk_all("d1", 1, P,           0, P,           0);
      step(0, 32'd0);           chk_all("d2", 1, P + 'h04,    0, P,           1);
      step(1, P + 'h103);       chk_all("d3", 0, P + 'h08,    0, P,           2);
      step(0, 32'd0);           chk_all("d4", 1, P + 'h100,   0, P + 'h100,   2);
      step(0, 32'd0);           chk_all("d5", 1, P + 'h104,   0, P + 'h100,   2);
      step(0, 32'd0);           chk_all("d6", 1, P + 'h108,   0, P + 'h100,   2);
      step(0, 32'd0);           chk_all("d7", 1, P + 'h10C,   0, P + 'h100,   3);
      step(0, 32'd0);           chk_all("d8", 0, P + 'h110,   1, P + 'h100,   3);
      step(0, 32'd0);           chk_all("d9", 1, P + 'h110,   1, P + 'h104,   2);

      // Redirect coinciding with a pop and an arriving response.
      do_reset(1, 1);
      @(negedge clk);
      chk_all("e0", 0, P, 0, P, 0);
      step(0, 32'd0);           chk_all("e1", 1, P,           0, P,           0);
      step(0, 32'd0);           chk_all("e2", 1, P + 'h04,    0, P,           1);
      step(1, P + 'h202);       chk_all("e3", 0, P + 'h08,    1, P,           1);
      step(0, 32'd0);           chk_all("e4", 1, P + 'h200,   0, P + 'h200,   0);
      step(0, 32'd0);           chk_all("e5", 1, P + 'h204,   0, P + 'h200,   1);
      step(0, 32'd0);           chk_all("e6", 1, P + 'h208,   1, P + 'h200,   1);
      step(0, 32'd0);           chk_all("e7", 1, P + 'h20C,   1, P + 'h204,   1);

      // Asynchronous reset between clock edges in mid-stream.
      do_reset(1, 1);
      @(negedge clk);
      step(0, 32'd0);
      step(0, 32'd0);
      step(0, 32'd0);
      step(0, 32'd0);           chk_all("f4", 1, P + 'h0C,    1, P + 'h04,    1);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk_rst("f_async");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      chk_all("g0", 0, P, 0, P, 0);
      step(0, 32'd0);           chk_all("g1", 1, P,           0, P,           0);
      step(0, 32'd0);           chk_all("g2", 1, P + 'h04,    0, P,           1);
      step(0, 32'd0);           chk_all("g3", 1, P + 'h08,    1, P,           1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end feeding the decode/execute core of the Small_MIPS processor.
- Issues word reads to instruction memory ahead of the core and buffers returned words with their PCs in a small prefetch FIFO.
- Presents one instruction at a time to the core through a valid/ready handshake.
- Handles PC redirects (jr $ra) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- PC_INIT, 32'h80020000, fetch address after reset; must equal mem_start.
- DEPTH, 4, prefetch FIFO entries; also the cap on FIFO occupancy plus outstanding requests; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request valid.
- imem_addr  out  32  word-aligned request address.
- imem_busy  in  1  memory cannot accept; a request is accepted when imem_req && !imem_busy.
- imem_rvalid  in  1  response data valid; responses return in order, at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction word.
- instr_valid  out  1  FIFO head valid toward the core.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of the head instruction.
- instr_next_pc  out  32  instr_pc + 4.
- instr_ready  in  1  core consumes the head this cycle when instr_valid && instr_ready.
- redirect  in  1  single-cycle pulse: flush and refetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored (forced to 0).
- outstanding  out  3  in-flight accepted requests not yet returned; for debug and verification.

Behaviour:
- Reset (reset_n low, asynchronous):
  - fetch_pc = PC_INIT, head_pc = PC_INIT.
  - FIFO empty, outstanding = 0, drop_cnt = 0, state = IDLE.
  - Outputs: imem_req = 0, instr_valid = 0, instr = 0, instr_pc = PC_INIT.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: one cycle after reset release, then RUN. No requests are issued in IDLE.
  - RUN → FLUSH on redirect when outstanding responses must be dropped (drop_cnt becomes nonzero).
  - RUN → RUN on redirect when nothing is in flight.
  - FLUSH → RUN when drop_cnt reaches 0 and no redirect occurs that cycle.
- Issue rule:
  - imem_req = (state != IDLE) && (fifo_count + outstanding < DEPTH) && !redirect.
  - imem_addr = fetch_pc.
  - On acceptance: fetch_pc += 4 (32-bit wrap), outstanding += 1.
  - imem_addr holds stable while imem_busy is high.
- Response rule:
  - If drop_cnt > 0: the word is discarded and drop_cnt -= 1.
  - Otherwise: the word is pushed into the FIFO.
  - Either way, outstanding -= 1.
  - The FIFO cannot overflow because of the credit rule. An imem_rvalid with outstanding == 0 is a protocol error: ignore it, and the bench flags it.
- Output:
  - instr_valid = FIFO non-empty.
  - instr = head word, instr_pc = head_pc, instr_next_pc = head_pc + 4.
  - On pop, head_pc += 4.
  - Latency from acceptance to instr_valid = memory latency + 1 cycle (registered FIFO). An empty FIFO does not bypass the register.
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged.
  - Accept and response in the same cycle: outstanding unchanged.
- Redirect (highest priority, in the cycle it is asserted):
  - FIFO cleared, and any pop that cycle is void.
  - fetch_pc and head_pc set to {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - drop_cnt = outstanding − (response arriving this cycle ? 1 : 0), plus any existing drop_cnt already folded into outstanding. Equivalently: after redirect, every response still in flight is dropped.
  - A redirect during FLUSH re-applies the same rule.
- Requests may issue during FLUSH at the new fetch_pc. In-order return guarantees that exactly drop_cnt stale words precede the new ones.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset release that belong to pre-reset requests are not supported; the memory is reset by the same reset.

Decomposition:
- Shared package (extend params.sv): mem_start, sz_word, the fetch FSM state enum, and an instruction/PC entry typedef {pc[31:0], word[31:0]}.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO with push, pop, flush, count, and head outputs.
- The credit logic, drop counter and FSM stay in fetch_unit.

Test Plan:
- Reset release with a 1-cycle-latency memory, instr_ready = 1 → first request at addr 32'h80020000 one cycle after IDLE. instr_pc sequence 0x80020000, 0x80020004, 0x80020008 on consecutive cycles with matching memory words.
- instr_ready = 0 held, fixed latency → exactly DEPTH = 4 requests accepted, then imem_req = 0. fifo_count = 4, outstanding = 0. Releasing ready resumes issue on the next cycle.
- imem_busy high for 3 cycles on the second request → imem_addr held at 0x80020004 throughout. No duplicate or skipped PC at the output.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x80020103 → fetch restarts at 0x80020100. Both stale words are discarded. The first instr_valid shows instr_pc = 0x80020100.
- Redirect in the same cycle as a response and a pop → popped word ignored, responding word counted out of outstanding. Output continues correctly from redirect_pc.
- Async reset_n asserted mid-stream, between clock edges → instr_valid and imem_req drop to 0 immediately. After release, fetch restarts at PC_INIT.
